fb_write_scheduler: RTL and testbench

//  Owns the single BRAM port of the 640x480 bin-index frame buffer and shares it between two requesters.

---
 rtl/fb_write_scheduler_if.sv | 13 +
 rtl/fb_write_scheduler.sv | 144 ++++++++++++++
 tb/tb_fb_write_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_scheduler_if.sv
// Writer-side valid/ready handshake into the frame-buffer write scheduler.
interface fb_write_scheduler_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/fb_write_scheduler.sv
// Arbitrates the single frame-buffer BRAM port between scan-out reads (priority)
// and FIFO-queued bin writes, and sweep-clears the buffer after reset or on request.
module fb_write_scheduler #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 3,
    parameter int FB_SIZE   = 307200,
    parameter int DEPTH     = 16,
    parameter int CLEAR_VAL = 0
) (
    input  logic                   video_clk,
    input  logic                   reset_n,
    input  logic                   clear_req,
    input  logic                   fetch_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    fb_write_scheduler_if.slave    wr_if,
    output logic [ADDR_W-1:0]      bram_addr,
    output logic                   bram_we,
    output logic [DATA_W-1:0]      bram_din,
    output logic                   fb_ready,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [DATA_W-1:0] CLR_DATA  = DATA_W'(CLEAR_VAL);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [LVL_W-1:0]  level_r;
    entry_t            mem_r [DEPTH];
    entry_t            head_s;
    logic              wr_ready_s;
    logic              push_s;
    logic              store_s;
    logic              pop_s;

    // Ready depends only on registered state, never on wr_valid.
    assign wr_ready_s     = (state_r == ST_RUN) && (level_r < FULL_LVL);
    assign wr_if.wr_ready = wr_ready_s;
    assign fifo_level     = level_r;
    assign head_s         = mem_r[rd_ptr_r];

    // Qualify the accepted write (out-of-range addresses are swallowed) and the blanking pop.
    always_comb begin
        push_s  = wr_if.wr_valid && wr_ready_s;
        store_s = 1'b0;
        pop_s   = 1'b0;
        if ((state_r == ST_RUN) && !clear_req) begin
            store_s = push_s && (wr_if.wr_addr <= LAST_ADDR);
            pop_s   = !fetch_en && (level_r != {LVL_W{1'b0}});
        end else begin
            store_s = 1'b0;
            pop_s   = 1'b0;
        end
    end

    // FIFO storage; contents are only ever read under a non-zero level.
    always_ff @(posedge video_clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= '{addr: wr_if.wr_addr, data: wr_if.wr_data};
        end
    end

    // Control FSM with registered BRAM port, ready flag and FIFO bookkeeping.
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= '0;
            rd_ptr_r  <= '0;
            wr_ptr_r  <= '0;
            level_r   <= '0;
            bram_addr <= '0;
            bram_we   <= 1'b0;
            bram_din  <= '0;
            fb_ready  <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    bram_addr <= clr_ptr_r;
                    bram_we   <= 1'b1;
                    bram_din  <= CLR_DATA;
                    fb_ready  <= 1'b0;
                    if (clr_ptr_r == LAST_ADDR) begin
                        state_r   <= ST_RUN;
                        clr_ptr_r <= '0;
                    end else begin
                        clr_ptr_r <= clr_ptr_r + ADDR_ONE;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= '0;
                        fb_ready  <= 1'b0;
                        bram_we   <= 1'b0;
                        rd_ptr_r  <= '0;
                        wr_ptr_r  <= '0;
                        level_r   <= '0;
                    end else begin
                        fb_ready <= 1'b1;
                        if (fetch_en) begin
                            bram_addr <= rd_addr;
                            bram_we   <= 1'b0;
                        end else if (pop_s) begin
                            bram_addr <= head_s.addr;
                            bram_din  <= head_s.data;
                            bram_we   <= 1'b1;
                        end else begin
                            bram_we   <= 1'b0;
                        end
                        if (store_s) begin
                            wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        end
                        if (pop_s) begin
                            rd_ptr_r <= rd_ptr_r + PTR_ONE;
                        end
                        level_r <= level_r + LVL_W'(store_s) - LVL_W'(pop_s);
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= '0;
                    rd_ptr_r  <= '0;
                    wr_ptr_r  <= '0;
                    level_r   <= '0;
                    bram_we   <= 1'b0;
                    fb_ready  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: directed scenarios plus randomized traffic against a queue-based model.
module tb_fb_write_scheduler;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 3;
    localparam int FB_SIZE = 16;
    localparam int DEPTH   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              video_clk = 1'b0;
    logic              reset_n   = 1'b0;
    logic              clear_req = 1'b0;
    logic              fetch_en  = 1'b0;
    logic [ADDR_W-1:0] rd_addr   = '0;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [DATA_W-1:0] bram_din;
    logic              fb_ready;
    logic [2:0]        fifo_level;

    fb_write_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

    fb_write_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_SIZE(FB_SIZE),
                         .DEPTH(DEPTH), .CLEAR_VAL(0)) dut (
        .video_clk (video_clk),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .fetch_en  (fetch_en),
        .rd_addr   (rd_addr),
        .wr_if     (wr_if),
        .bram_addr (bram_addr),
        .bram_we   (bram_we),
        .bram_din  (bram_din),
        .fb_ready  (fb_ready),
        .fifo_level(fifo_level)
    );

    always #5 video_clk = ~video_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: sweep progress, pending-write queue, expected port values.
    bit                m_run;
    int                m_clr;
    ent_t              q[$];
    logic [ADDR_W-1:0] e_addr;
    logic              e_we;
    logic [DATA_W-1:0] e_din;
    logic              e_fb;
    bit                addr_chk;
    bit                din_chk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_clr = 0;
        q.delete();
        e_addr = '0; e_we = 1'b0; e_din = '0; e_fb = 1'b0;
        addr_chk = 1'b1; din_chk = 1'b1;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit   rdy;
        ent_t e;
        if (!reset_n) begin
            model_reset();
            return;
        end
        rdy = m_run && (q.size() < DEPTH);
        if (!m_run) begin
            e_addr = ADDR_W'(m_clr); e_we = 1'b1; e_din = '0; e_fb = 1'b0;
            addr_chk = 1'b1; din_chk = 1'b1;
            if (m_clr == FB_SIZE - 1) begin
                m_run = 1'b1;
                m_clr = 0;
            end else begin
                m_clr++;
            end
        end else if (clear_req) begin
            q.delete();
            m_run = 1'b0; m_clr = 0;
            e_we = 1'b0; e_fb = 1'b0; addr_chk = 1'b0; din_chk = 1'b0;
        end else begin
            e_fb = 1'b1; e_we = 1'b0; din_chk = 1'b0;
            if (fetch_en) begin
                e_addr = rd_addr; addr_chk = 1'b1;
            end else if (q.size() != 0) begin
                e = q.pop_front();
                e_addr = e.a; e_din = e.d; e_we = 1'b1;
                addr_chk = 1'b1; din_chk = 1'b1;
            end
            if (rdy && wr_if.wr_valid && (wr_if.wr_addr < FB_SIZE)) begin
                q.push_back('{a: wr_if.wr_addr, d: wr_if.wr_data});
            end
        end
    endtask

    task automatic step();
        @(posedge video_clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge video_clk) begin
        check("bram_we", bram_we, e_we);
        check("fb_ready", fb_ready, e_fb);
        check("wr_ready", wr_if.wr_ready, (m_run && (q.size() < DEPTH)) ? 32'd1 : 32'd0);
        check("fifo_level", fifo_level, q.size());
        if (addr_chk) check("bram_addr", bram_addr, e_addr);
        if (din_chk)  check("bram_din", bram_din, e_din);
    end

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = '0;
        wr_if.wr_data  = '0;
        model_reset();
        step();
        step();
        check("rst_we", bram_we, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_fb_ready", fb_ready, 0);
        check("rst_wr_ready", wr_if.wr_ready, 0);
        check("rst_level", fifo_level, 0);

        // T1: initial sweep of 16 addresses, then ready.
        reset_n = 1'b1;
        for (int i = 0; i < FB_SIZE; i++) begin
            step();
            check("t1_addr", bram_addr, i);
            check("t1_we", bram_we, 1);
            check("t1_din", bram_din, 0);
            check("t1_fb_low", fb_ready, 0);
        end
        step();
        check("t1_fb_ready", fb_ready, 1);
        check("t1_wr_ready", wr_if.wr_ready, 1);
        check("t1_we_off", bram_we, 0);

        // T2: read has priority; a push is queued, not written.
        fetch_en = 1'b1; rd_addr = 19'd5;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 19'd3; wr_if.wr_data = 3'd6;
        step();
        wr_if.wr_valid = 1'b0;
        check("t2_addr", bram_addr, 5);
        check("t2_we", bram_we, 0);
        check("t2_level", fifo_level, 1);

        // T3: blanking commits the queued write.
        fetch_en = 1'b0;
        step();
        check("t3_we", bram_we, 1);
        check("t3_addr", bram_addr, 3);
        check("t3_din", bram_din, 6);
        step();
        check("t3_level", fifo_level, 0);
        check("t3_we_off", bram_we, 0);

        // T4: fill the FIFO during display, stall the 5th, drain in order.
        fetch_en = 1'b1; rd_addr = 19'd9;
        for (int k = 0; k < DEPTH; k++) begin
            wr_if.wr_valid = 1'b1; wr_if.wr_addr = 19'(8 + k); wr_if.wr_data = 3'(k);
            step();
        end
        check("t4_level_full", fifo_level, 4);
        check("t4_wr_ready_full", wr_if.wr_ready, 0);
        wr_if.wr_addr = 19'd12; wr_if.wr_data = 3'd7;
        step();
        step();
        check("t4_stalled", fifo_level, 4);
        fetch_en = 1'b0; wr_if.wr_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            step();
            check("t4_drain_we", bram_we, 1);
            check("t4_drain_addr", bram_addr, 8 + k);
            check("t4_drain_din", bram_din, k);
        end
        step();
        check("t4_drained", bram_we, 0);

        // T5: out-of-range address is accepted but dropped.
        check("t5_wr_ready", wr_if.wr_ready, 1);
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 19'd20; wr_if.wr_data = 3'd5;
        step();
        wr_if.wr_valid = 1'b0;
        check("t5_level", fifo_level, 0);
        step();
        check("t5_no_write", bram_we, 0);

        // T6: clear request flushes the FIFO and re-sweeps; reset mid-sweep restarts it.
        fetch_en = 1'b1;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 19'd1; wr_if.wr_data = 3'd1;
        step();
        wr_if.wr_addr = 19'd2; wr_if.wr_data = 3'd2;
        step();
        wr_if.wr_valid = 1'b0;
        check("t6_level2", fifo_level, 2);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0; fetch_en = 1'b0;
        check("t6_flush", fifo_level, 0);
        check("t6_fb_low", fb_ready, 0);
        check("t6_we_off", bram_we, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_sweep_addr", bram_addr, i);
            check("t6_sweep_we", bram_we, 1);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_we", bram_we, 0);
        check("t6_rst_addr", bram_addr, 0);
        check("t6_rst_level", fifo_level, 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < FB_SIZE; i++) begin
            step();
            check("t6_resweep_addr", bram_addr, i);
        end
        step();
        check("t6_fb_ready", fb_ready, 1);

        // Randomized traffic; the negedge compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            fetch_en       = ($urandom_range(0, 99) < 45);
            clear_req      = ($urandom_range(0, 299) == 0);
            rd_addr        = 19'($urandom_range(0, FB_SIZE - 1));
            wr_if.wr_valid = ($urandom_range(0, 99) < 60);
            wr_if.wr_addr  = 19'($urandom_range(0, FB_SIZE + 5));
            wr_if.wr_data  = 3'($urandom_range(0, 7));
            step();
        end
        clear_req = 1'b0; fetch_en = 1'b0; wr_if.wr_valid = 1'b0;
        step();
        @(negedge video_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
